// File: rtl/cnvrow_sched_pkg.sv
// cnvrow_sched_pkg: shared sizing, state encoding and log2 helper for the row sequencer.
package cnvrow_sched_pkg;

    localparam int LENROW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MAC    = 3'd2,
        ACC    = 3'd3,
        ROWEND = 3'd4
    } state_t;

    function automatic int C_LOG_2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cnvrow_sched_if.sv
// cnvrow_sched_if: row-start handshake, operand fetch and MAC launch/finish signals of one conv row.
interface cnvrow_sched_if
    import cnvrow_sched_pkg::*;
#(
    parameter int LENROW    = LENROW_DEF,
    parameter int POS_WIDTH = C_LOG_2(LENROW) + 1
);
    logic                         CTLCNV_StaRow;
    logic [POS_WIDTH-1:0]         CTLCNV_CfgLen;
    logic                         CNVCTL_Rdy;
    logic                         CNVCTL_FnhRow;
    logic                         CNVBUF_Req;
    logic                         BUFCNV_Ack;
    logic                         PECMAC_Sta;
    logic                         MACPEC_Fnh0;
    logic                         MACPEC_Fnh1;
    logic                         MACPEC_Fnh2;
    logic                         PECCNV_PlsAcc;
    logic                         PECCNV_FnhRow;
    logic [C_LOG_2(LENROW)-1:0]   CNVCTL_Pos;

    modport master (
        input  CTLCNV_StaRow, CTLCNV_CfgLen, BUFCNV_Ack, MACPEC_Fnh0, MACPEC_Fnh1, MACPEC_Fnh2,
        output CNVCTL_Rdy, CNVCTL_FnhRow, CNVBUF_Req, PECMAC_Sta, PECCNV_PlsAcc, PECCNV_FnhRow, CNVCTL_Pos
    );

    modport slave (
        output CTLCNV_StaRow, CTLCNV_CfgLen, BUFCNV_Ack, MACPEC_Fnh0, MACPEC_Fnh1, MACPEC_Fnh2,
        input  CNVCTL_Rdy, CNVCTL_FnhRow, CNVBUF_Req, PECMAC_Sta, PECCNV_PlsAcc, PECCNV_FnhRow, CNVCTL_Pos
    );

endinterface

// File: rtl/cnvrow_sched_fnh_join.sv
// cnvrow_sched_fnh_join: three sticky done flags with synchronous clear and an all-done flag
// that already counts the finish pulses arriving this cycle.
module cnvrow_sched_fnh_join (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] fnh,
    output logic       all_done
);

    logic [2:0] done_q, done_d, hit;

    // A clear wins over a coincident finish: that pulse belongs to the previous launch.
    always_comb begin
        hit      = en ? fnh : 3'b000;
        done_d   = clr ? 3'b000 : (done_q | hit);
        all_done = !clr && (&(done_q | hit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 3'b000;
        else        done_q <= done_d;
    end

endmodule

// File: rtl/cnvrow_sched.sv
// cnvrow_sched: per-position fetch / launch / join / accumulate sequencer for one conv row,
// counting the position down from CfgLen-1 and closing the row with a finish strobe.
module cnvrow_sched
    import cnvrow_sched_pkg::*;
#(
    parameter int LENROW    = LENROW_DEF,
    parameter int POS_WIDTH = C_LOG_2(LENROW) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    cnvrow_sched_if.master      bus
);

    localparam int                   PW      = C_LOG_2(LENROW);
    localparam logic [POS_WIDTH-1:0] LEN_MAX = POS_WIDTH'(LENROW);
    localparam logic [PW-1:0]        POS_MAX = PW'(LENROW - 1);

    state_t         state_q, state_d;
    logic [PW-1:0]  pos_q, pos_d, lenm1_q, lenm1_d, cfg_m1;
    logic           rdy_q, rdy_d, req_q, req_d, sta_q, sta_d;
    logic           acc_q, acc_d, fnh_q, fnh_d, all_done;

    cnvrow_sched_fnh_join u_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sta_q),
        .en       (state_q == MAC),
        .fnh      ({bus.MACPEC_Fnh2, bus.MACPEC_Fnh1, bus.MACPEC_Fnh0}),
        .all_done (all_done)
    );

    // Row length is stored as length-1 so 0 behaves as 1 and oversize clamps to the full row.
    always_comb begin
        cfg_m1  = (bus.CTLCNV_CfgLen == '0) ? '0 :
                  (bus.CTLCNV_CfgLen > LEN_MAX) ? POS_MAX :
                  PW'(bus.CTLCNV_CfgLen - POS_WIDTH'(1));
        state_d = state_q;
        pos_d   = pos_q;
        lenm1_d = lenm1_q;
        case (state_q)
            IDLE: if (bus.CTLCNV_StaRow) begin
                state_d = LOAD;
                lenm1_d = cfg_m1;
                pos_d   = cfg_m1;
            end
            LOAD: state_d = bus.BUFCNV_Ack ? MAC : LOAD;
            MAC:  state_d = all_done ? ACC : MAC;
            ACC: begin
                state_d = (pos_q == '0) ? ROWEND : LOAD;
                pos_d   = (pos_q == '0) ? pos_q : pos_q - PW'(1);
            end
            ROWEND: begin
                state_d = IDLE;
                pos_d   = lenm1_q;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = state_d == IDLE;
        req_d = state_d == LOAD;
        sta_d = (state_q == LOAD) && bus.BUFCNV_Ack;
        acc_d = state_d == ACC;
        fnh_d = state_d == ROWEND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= POS_MAX;
            lenm1_q <= POS_MAX;
            rdy_q   <= 1'b1;
            req_q   <= 1'b0;
            sta_q   <= 1'b0;
            acc_q   <= 1'b0;
            fnh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            lenm1_q <= lenm1_d;
            rdy_q   <= rdy_d;
            req_q   <= req_d;
            sta_q   <= sta_d;
            acc_q   <= acc_d;
            fnh_q   <= fnh_d;
        end
    end

    assign bus.CNVCTL_Rdy    = rdy_q;
    assign bus.CNVBUF_Req    = req_q;
    assign bus.PECMAC_Sta    = sta_q;
    assign bus.PECCNV_PlsAcc = acc_q;
    assign bus.PECCNV_FnhRow = fnh_q;
    assign bus.CNVCTL_FnhRow = fnh_q;
    assign bus.CNVCTL_Pos    = pos_q;

endmodule

// File: tb/tb_cnvrow_sched.sv
// tb_cnvrow_sched: drives rows open-loop from a per-position timeline (ack wait, MAC finish times)
// and checks every cycle's outputs against that timeline, with ignored-input noise injected.
module tb_cnvrow_sched;

    localparam logic [5:0] E_IDLE = 6'b100000;
    localparam logic [5:0] E_REQ  = 6'b010000;
    localparam logic [5:0] E_STA  = 6'b001000;
    localparam logic [5:0] E_MAC  = 6'b000000;
    localparam logic [5:0] E_ACC  = 6'b000100;
    localparam logic [5:0] E_END  = 6'b000011;

    logic clk, rst_n;
    int   total, bad, last_pos;

    cnvrow_sched_if #(.LENROW(16)) bus ();

    cnvrow_sched #(.LENROW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic nz();
        return $urandom_range(0, 3) == 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [5:0] e, input int ep);
        chk({tag, " strobes"}, 8'({bus.CNVCTL_Rdy, bus.CNVBUF_Req, bus.PECMAC_Sta,
                                   bus.PECCNV_PlsAcc, bus.PECCNV_FnhRow, bus.CNVCTL_FnhRow}), 8'(e));
        chk({tag, " pos"}, 8'(bus.CNVCTL_Pos), 8'(ep));
    endtask

    task automatic drive(input logic sr, input logic [4:0] cl, input logic ak, input logic [2:0] fn);
        bus.CTLCNV_StaRow = sr;
        bus.CTLCNV_CfgLen = cl;
        bus.BUFCNV_Ack    = ak;
        {bus.MACPEC_Fnh2, bus.MACPEC_Fnh1, bus.MACPEC_Fnh0} = fn;
    endtask

    task automatic step(input string tag, input logic [5:0] e, input int ep,
                        input logic sr, input logic [4:0] cl, input logic ak, input logic [2:0] fn);
        @(negedge clk);
        check_outs(tag, e, ep);
        drive(sr, cl, ak, fn);
    endtask

    // Negative latency arguments mean "pick at random"; abort_p resets the DUT mid-MAC of that position.
    task automatic do_row(input int cfg, input int alat, input int f0, input int f1, input int f2,
                          input bit coinc, input int abort_p);
        int n, a, dm;
        int d[3];
        n = (cfg == 0) ? 1 : (cfg > 16) ? 16 : cfg;
        step($sformatf("start cfg%0d", cfg), E_IDLE, last_pos, 1'b1, 5'(cfg), nz(), 3'($urandom));
        for (int p = n - 1; p >= 0; p--) begin
            a = (alat < 0) ? $urandom_range(0, 4) : alat;
            for (int k = 0; k <= a; k++)
                step($sformatf("req p%0d k%0d", p, k), E_REQ, p, nz(), 5'($urandom), k == a, 3'($urandom));
            d[0] = (f0 < 0) ? $urandom_range(1, 6) : f0;
            d[1] = (f1 < 0) ? $urandom_range(1, 6) : f1;
            d[2] = (f2 < 0) ? $urandom_range(1, 6) : f2;
            dm = d[0];
            if (d[1] > dm) dm = d[1];
            if (d[2] > dm) dm = d[2];
            step($sformatf("sta p%0d", p), E_STA, p, nz(), 5'($urandom), nz(),
                 coinc ? 3'b010 : 3'($urandom));
            for (int k = 1; k <= dm; k++) begin
                if (p == abort_p && k == 2) begin
                    @(negedge clk);
                    drive(1'b0, 5'd0, 1'b0, 3'b000);
                    rst_n = 1'b0;
                    #1;
                    check_outs("async reset", E_IDLE, 15);
                    @(negedge clk);
                    rst_n = 1'b1;
                    last_pos = 15;
                    return;
                end
                step($sformatf("mac p%0d k%0d", p, k), E_MAC, p, nz(), 5'($urandom), nz(),
                     {k == d[2], k == d[1], k == d[0]});
            end
            step($sformatf("acc p%0d", p), E_ACC, p, nz(), 5'($urandom), nz(), 3'($urandom));
        end
        step("rowend", E_END, 0, nz(), 5'($urandom), nz(), 3'($urandom));
        last_pos = n - 1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        last_pos = 15;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 3'b000);
        repeat (2) @(negedge clk);
        check_outs("reset", E_IDLE, 15);
        rst_n = 1'b1;
        do_row(16, 0, 5, 5, 5, 1'b0, -1);
        do_row(1, 0, 3, 7, 5, 1'b0, -1);
        do_row(1, 0, 2, 4, 2, 1'b1, -1);
        do_row(3, 10, -1, -1, -1, 1'b0, -1);
        do_row(0, -1, -1, -1, -1, 1'b0, -1);
        do_row(20, -1, -1, -1, -1, 1'b0, -1);
        do_row(16, -1, -1, -1, -1, 1'b0, 7);
        do_row(5, -1, -1, -1, -1, 1'b0, -1);
        for (int r = 0; r < 15; r++)
            do_row($urandom_range(0, 20), -1, -1, -1, -1, 1'($urandom_range(0, 1)), -1);
        step("final idle", E_IDLE, last_pos, 1'b0, 5'd0, 1'b0, 3'b000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
